// File: rtl/dab_pwm_gen.sv
// Dual-active-bridge PWM generator: a shared angle counter drives primary and
// phase-shifted secondary bridge patterns, each with deadtime insertion.
`timescale 1ns / 1ps
module dab_pwm_gen #(
    parameter logic [8:0] HALF     = 9'd255,
    parameter logic [7:0] DEADTIME = 8'd10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CE,
    input  logic              sync,
    input  logic              trigger,
    input  logic signed [8:0] tau1,
    input  logic signed [8:0] tau2,
    input  logic signed [8:0] phi,
    input  logic        [1:0] modo,
    output logic        [3:0] Sp,
    output logic        [3:0] Ss,
    output logic              period_start,
    output logic        [1:0] modo_act
);

    localparam logic [9:0] PERIOD = {HALF, 1'b0};

    localparam logic [3:0] GATE_POS  = 4'b1001;
    localparam logic [3:0] GATE_ZERO = 4'b0101;
    localparam logic [3:0] GATE_NEG  = 4'b0110;

    typedef enum logic {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic        [8:0] a_q, a_d;
    logic              sync_q;
    logic              sync_rise;
    logic              copy;
    logic        [8:0] sh_tau1_q, sh_tau2_q, act_tau1_q, act_tau2_q;
    logic signed [8:0] sh_phi_q, act_phi_q;
    logic        [1:0] sh_modo_q, act_modo_q;
    logic        [8:0] phi_mag;
    logic        [9:0] a2;
    logic        [3:0] tgt_now [2];
    logic        [3:0] pat_q [2], pat_d [2];
    logic        [3:0] tgt_q [2], tgt_d [2];
    logic        [7:0] cnt_q [2], cnt_d [2];
    logic        [3:0] gate_q [2], gate_d [2];
    logic              period_start_q;

    function automatic logic [8:0] clamp_tau(input logic signed [8:0] t);
        if (t[8]) return 9'd0;
        if ($unsigned(t) > HALF) return HALF;
        return $unsigned(t);
    endfunction

    function automatic logic signed [8:0] clamp_phi(input logic signed [8:0] p);
        logic signed [9:0] pw, lim, nlim;
        pw   = {p[8], p};
        lim  = $signed({1'b0, HALF});
        nlim = -lim;
        if (pw > lim) return $signed(lim[8:0]);
        if (pw < nlim) return $signed(nlim[8:0]);
        return p;
    endfunction

    // Pulse centred in each half period: +1 in the first half, -1 in the second.
    function automatic logic [3:0] gate_target(input logic [9:0] ang, input logic [8:0] tau);
        logic [9:0] h, o, t;
        logic       first;
        first = (ang < {1'b0, HALF});
        h     = first ? ang : ang - {1'b0, HALF};
        t     = {1'b0, tau};
        o     = ({1'b0, HALF} - t) >> 1;
        if (h >= o && h < o + t) return first ? GATE_POS : GATE_NEG;
        return GATE_ZERO;
    endfunction

    // Mode FSM and angle counter next state.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        copy      = 1'b0;
        sync_rise = sync & ~sync_q;
        unique case (state_q)
            StIdle: begin
                if (sync_rise) begin
                    state_d = StRun;
                    a_d     = '0;
                    copy    = 1'b1;
                end
            end
            StRun: begin
                if ({1'b0, a_q} == PERIOD - 10'd1) begin
                    a_d  = '0;
                    copy = 1'b1;
                end else begin
                    a_d = a_q + 9'd1;
                end
                // Realignment only resets the angle; it does not load the shadow set.
                if (sync_rise) a_d = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    // Secondary angle (a - phi) wrapped into one period with +/- PERIOD correction.
    always_comb begin
        phi_mag = act_phi_q[8] ? 9'($unsigned(-act_phi_q)) : $unsigned(act_phi_q);
        if (!act_phi_q[8]) begin
            if ({1'b0, a_q} >= {1'b0, phi_mag}) a2 = {1'b0, a_q} - {1'b0, phi_mag};
            else a2 = {1'b0, a_q} + PERIOD - {1'b0, phi_mag};
        end else begin
            a2 = {1'b0, a_q} + {1'b0, phi_mag};
            if (a2 >= PERIOD) a2 = a2 - PERIOD;
        end
        tgt_now[0] = gate_target({1'b0, a_q}, act_tau1_q);
        tgt_now[1] = gate_target(a2, act_tau2_q);
    end

    // Deadtime insertion per bridge: show P & T until the count expires, then apply T.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            pat_d[b]  = pat_q[b];
            tgt_d[b]  = tgt_q[b];
            cnt_d[b]  = cnt_q[b];
            gate_d[b] = 4'b0000;
            if (state_q == StRun) begin
                if (cnt_q[b] != 8'd0) begin
                    if (tgt_now[b] != tgt_q[b]) begin
                        cnt_d[b]  = DEADTIME;
                        tgt_d[b]  = tgt_now[b];
                        gate_d[b] = pat_q[b] & tgt_now[b];
                    end else if (cnt_q[b] == 8'd1) begin
                        cnt_d[b]  = 8'd0;
                        pat_d[b]  = tgt_now[b];
                        gate_d[b] = tgt_now[b];
                    end else begin
                        cnt_d[b]  = cnt_q[b] - 8'd1;
                        gate_d[b] = pat_q[b] & tgt_now[b];
                    end
                end else if (tgt_now[b] != pat_q[b]) begin
                    if (DEADTIME == 8'd0) begin
                        pat_d[b]  = tgt_now[b];
                        gate_d[b] = tgt_now[b];
                    end else begin
                        cnt_d[b]  = DEADTIME;
                        tgt_d[b]  = tgt_now[b];
                        gate_d[b] = pat_q[b] & tgt_now[b];
                    end
                end else begin
                    gate_d[b] = pat_q[b];
                end
            end
        end
    end

    // All state, advancing only on CE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            a_q            <= '0;
            sync_q         <= 1'b0;
            sh_tau1_q      <= 9'd255;
            sh_tau2_q      <= 9'd147;
            sh_phi_q       <= -9'sd9;
            sh_modo_q      <= 2'd0;
            act_tau1_q     <= 9'd255;
            act_tau2_q     <= 9'd147;
            act_phi_q      <= -9'sd9;
            act_modo_q     <= 2'd0;
            period_start_q <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                pat_q[b]  <= GATE_ZERO;
                tgt_q[b]  <= GATE_ZERO;
                cnt_q[b]  <= 8'd0;
                gate_q[b] <= 4'b0000;
            end
        end else if (CE) begin
            state_q        <= state_d;
            a_q            <= a_d;
            sync_q         <= sync;
            period_start_q <= (state_q == StRun) && (a_q == 9'd0);
            if (copy) begin
                act_tau1_q <= sh_tau1_q;
                act_tau2_q <= sh_tau2_q;
                act_phi_q  <= sh_phi_q;
                act_modo_q <= sh_modo_q;
            end
            if (trigger && modo != 2'd3) begin
                sh_tau1_q <= clamp_tau(tau1);
                sh_tau2_q <= clamp_tau(tau2);
                sh_phi_q  <= clamp_phi(phi);
                sh_modo_q <= modo;
            end
            for (int b = 0; b < 2; b++) begin
                pat_q[b]  <= pat_d[b];
                tgt_q[b]  <= tgt_d[b];
                cnt_q[b]  <= cnt_d[b];
                gate_q[b] <= gate_d[b];
            end
        end
    end

    assign Sp           = gate_q[0];
    assign Ss           = gate_q[1];
    assign period_start = period_start_q;
    assign modo_act     = act_modo_q;

endmodule

// File: tb/tb_dab_pwm_gen.sv
// Randomized bench for dab_pwm_gen against an arithmetic reference model.
`timescale 1ns / 1ps
module tb_dab_pwm_gen;

    localparam int HALF = 255;
    localparam int PER  = 2 * HALF;
    localparam int DT   = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              CE = 1'b0;
    logic              sync = 1'b0;
    logic              trigger = 1'b0;
    logic signed [8:0] tau1 = '0;
    logic signed [8:0] tau2 = '0;
    logic signed [8:0] phi = '0;
    logic        [1:0] modo = '0;
    logic        [3:0] Sp, Ss;
    logic              period_start;
    logic        [1:0] modo_act;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    bit       m_run;
    int       m_a;
    bit       m_sync_prev;
    int       s_t1, s_t2, s_phi, s_modo;
    int       m_t1, m_t2, m_phi, m_modo;
    logic [3:0] m_p [2];
    logic [3:0] m_tgt [2];
    int       m_left [2];
    logic [3:0] e_sp, e_ss;
    bit       e_ps;

    dab_pwm_gen dut (
        .clk          (clk),
        .rst          (rst),
        .CE           (CE),
        .sync         (sync),
        .trigger      (trigger),
        .tau1         (tau1),
        .tau2         (tau2),
        .phi          (phi),
        .modo         (modo),
        .Sp           (Sp),
        .Ss           (Ss),
        .period_start (period_start),
        .modo_act     (modo_act)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [3:0] ref_gate(input int ang, input int tau);
        int h, o, lvl;
        h = ang % HALF;
        o = (HALF - tau) / 2;
        if (h >= o && h < o + tau) lvl = (ang < HALF) ? 1 : -1;
        else lvl = 0;
        if (lvl == 1) return 4'b1001;
        if (lvl == -1) return 4'b0110;
        return 4'b0101;
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    task automatic model_reset();
        m_run = 0; m_a = 0; m_sync_prev = 0;
        s_t1 = 255; s_t2 = 147; s_phi = -9; s_modo = 0;
        m_t1 = 255; m_t2 = 147; m_phi = -9; m_modo = 0;
        for (int b = 0; b < 2; b++) begin
            m_p[b] = 4'b0101; m_tgt[b] = 4'b0101; m_left[b] = 0;
        end
        e_sp = 0; e_ss = 0; e_ps = 0;
    endtask

    // Applied pattern changes only after DT stable cycles of a new target.
    task automatic dead_step(input int b, input logic [3:0] t, output logic [3:0] res);
        if (m_left[b] > 0 && t != m_tgt[b]) begin
            m_left[b] = DT; m_tgt[b] = t; res = m_p[b] & t;
        end else if (m_left[b] > 0) begin
            m_left[b] = m_left[b] - 1;
            if (m_left[b] == 0) m_p[b] = t;
            res = (m_left[b] == 0) ? t : (m_p[b] & t);
        end else if (t != m_p[b]) begin
            m_left[b] = DT; m_tgt[b] = t; res = m_p[b] & t;
        end else begin
            res = m_p[b];
        end
    endtask

    task automatic take_shadow();
        m_t1 = s_t1; m_t2 = s_t2; m_phi = s_phi; m_modo = s_modo;
    endtask

    task automatic model_step();
        bit rise, wrap;
        int a2;
        logic [3:0] r0, r1;
        rise = sync && !m_sync_prev;
        if (m_run) begin
            a2 = ((m_a - m_phi) % PER + PER) % PER;
            dead_step(0, ref_gate(m_a, m_t1), r0);
            dead_step(1, ref_gate(a2, m_t2), r1);
            e_sp = r0; e_ss = r1; e_ps = (m_a == 0);
            wrap = (m_a == PER - 1);
            m_a = rise ? 0 : (m_a + 1) % PER;
            if (wrap) take_shadow();
        end else begin
            e_sp = 0; e_ss = 0; e_ps = 0;
            if (rise) begin
                m_run = 1; m_a = 0; take_shadow();
            end
        end
        if (trigger && modo != 2'd3) begin
            s_t1   = clampi(int'(tau1), 0, HALF);
            s_t2   = clampi(int'(tau2), 0, HALF);
            s_phi  = clampi(int'(phi), -HALF, HALF);
            s_modo = int'(modo);
        end
        m_sync_prev = sync;
    endtask

    task automatic compare_all();
        check("Sp", 32'(Sp), 32'(e_sp));
        check("Ss", 32'(Ss), 32'(e_ss));
        check("period_start", 32'(period_start), 32'(e_ps));
        check("modo_act", 32'(modo_act), 32'(m_modo));
        check("shoot_through", 32'(Sp == 4'b1100 || Sp == 4'b0011 ||
                                   Ss == 4'b1100 || Ss == 4'b0011), 32'd0);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst) model_reset();
        else if (CE) model_step();
        #1;
        compare_all();
    endtask

    task automatic load(input int t1, input int t2, input int ph, input int md);
        tau1 = 9'(t1); tau2 = 9'(t2); phi = 9'(ph); modo = 2'(md);
        CE = 1'b1; trigger = 1'b1;
        cycle();
        trigger = 1'b0;
    endtask

    task automatic run(input int n);
        CE = 1'b1;
        for (int i = 0; i < n; i++) cycle();
    endtask

    function automatic logic signed [8:0] rand_tau();
        unique case ($urandom_range(0, 3))
            0: return 9'($urandom_range(0, 511));
            1: return 9'($urandom_range(0, 8));
            2: return 9'sd255;
            default: return 9'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        model_reset();
        rst = 1'b0;
        #2;
        check("reset_Sp", 32'(Sp), 32'd0);
        check("reset_Ss", 32'(Ss), 32'd0);
        check("reset_modo_act", 32'(modo_act), 32'd0);
        cycle();
        rst = 1'b1;
        run(5);

        // Full-width pulses, no phase shift.
        load(255, 255, 0, 0);
        run(3);
        sync = 1'b1;
        run(1100);
        // Narrower primary, then phase lag and lead.
        load(127, 255, 0, 1);
        run(1100);
        load(255, 255, 9, 2);
        run(1100);
        load(255, 255, -9, 0);
        run(1100);
        // Mid-period trigger, then ignored modo=3 trigger.
        while (m_a != 100) cycle();
        load(50, 200, 30, 2);
        run(200);
        load(10, 10, 100, 3);
        run(900);
        // Pulses shorter than the deadtime force retargeting during deadtime.
        load(3, 5, 1, 1);
        run(1100);

        // Random phase: gated CE, random triggers, occasional realignment.
        for (int i = 0; i < 5000; i++) begin
            CE      = ($urandom_range(0, 9) != 0);
            trigger = ($urandom_range(0, 39) == 0);
            tau1    = rand_tau();
            tau2    = rand_tau();
            phi     = 9'($urandom_range(0, 511));
            modo    = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 399) == 0) sync = ~sync;
            cycle();
        end
        trigger = 1'b0;
        sync = 1'b0;
        run(3);
        sync = 1'b1;
        run(3);

        // Asynchronous reset mid-run at a=300.
        begin
            int guard;
            guard = 0;
            while (m_a != 300 && guard < 1200) begin
                cycle();
                guard++;
            end
            check("reach_a300", 32'(m_a), 32'd300);
        end
        @(negedge clk);
        sync = 1'b0;
        rst = 1'b0;
        #1;
        check("async_Sp", 32'(Sp), 32'd0);
        check("async_Ss", 32'(Ss), 32'd0);
        check("async_ps", 32'(period_start), 32'd0);
        model_reset();
        cycle();
        rst = 1'b1;
        run(50);
        sync = 1'b1;
        run(700);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dab_pwm_gen.md
DAB_PWM_GEN -- requirements
Module: dab_pwm_gen

Interface
REQ-001 SHALL have parameter HALF, default 9'd255, giving steps per half switching period (255 = pi).
REQ-002 SHALL have parameter DEADTIME, default 8'd10, giving deadtime in CE-qualified clk cycles.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, with ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- CE  in  1  clock enable; all state advances only when CE=1
- sync  in  1  level; 0→1 starts modulation
- trigger  in  1  one-cycle pulse; new control set valid on tau1/tau2/phi/modo
- tau1  in  9 signed  primary pulse width, 0..255
- tau2  in  9 signed  secondary pulse width, 0..255
- phi  in  9 signed  secondary phase lag, -255..255
- modo  in  2  operating mode from controller; 3 = no new solution
- Sp  out  4  primary bridge gates {S1,S2,S3,S4}
- Ss  out  4  secondary bridge gates {S1,S2,S3,S4}
- period_start  out  1  one-cycle pulse at angle 0
- modo_act  out  2  mode of the active parameter set

Function
REQ-004 SHALL implement states IDLE and RUN; IDLE→RUN on CE=1 with a sync rising edge (sync registered, previous value 0, current value 1).
REQ-005 In IDLE, Sp and Ss SHALL be 4'b0000 and the angle counter SHALL be held at 0.
REQ-006 In RUN, the 9-bit angle counter a SHALL increment by 1 per CE cycle and wrap from 2*HALF-1 (509) to 0.
REQ-007 A sync rising edge in RUN SHALL force a to 0 on the next CE cycle (phase realignment); no other state change.
REQ-008 On trigger=1 with CE=1 and modo≠3, SHALL latch tau1, tau2, phi and modo into shadow registers; with modo=3 the shadow registers SHALL be unchanged.
REQ-009 Shadow values SHALL be copied to active registers only when a wraps to 0, or on the IDLE→RUN transition.
REQ-010 Negative tau SHALL clamp to 0; tau > HALF SHALL clamp to HALF; phi SHALL clamp to ±HALF; all clamps SHALL be applied on latch.
REQ-011 Primary level: h = a mod HALF; s = +1 if a < HALF, else -1; o = (HALF - tau1_act) >> 1; level = s if o ≤ h < o + tau1_act, else 0.
REQ-012 Secondary level SHALL use the same rule with tau2_act and a2 = (a - phi_act) mod 2*HALF, computed with explicit +/- 510 correction and no modulo operator.
REQ-013 Level-to-gate mapping SHALL be: +1→4'b1001, 0→4'b0101, -1→4'b0110.
REQ-014 Each bridge SHALL hold an applied pattern P. When the target pattern T differs from P:
- a deadtime counter SHALL load DEADTIME;
- the output SHALL be P & T while the counter is nonzero;
- at count expiry, P SHALL be set to T.
REQ-015 If T changes again during deadtime, the counter SHALL reload and P SHALL remain unchanged.
REQ-016 Gate outputs SHALL be registered, with exactly one CE cycle of latency from a to Sp/Ss.
REQ-017 period_start SHALL pulse for one CE cycle when a = 0 in RUN.
REQ-018 modo_act SHALL reflect the active set.
REQ-019 When CE=0, all registers SHALL hold their values.

Reset
REQ-020 On rst=0, the block SHALL go immediately to IDLE with Sp=Ss=0, period_start=0 and a=0.
REQ-021 On rst=0, shadow and active registers SHALL reset to tau1=255, tau2=147, phi=-9, modo=0; P SHALL reset to 4'b0101.
REQ-022 Reset asserted mid-RUN SHALL force the gates to 0 asynchronously, without waiting for deadtime.

Verification
REQ-023 Reset, trigger with tau1=tau2=255, phi=0, modo=0, then sync with CE=1 → Sp=1001 for a=0..254; Sp=0000 for 10 cycles after a=255; then Sp=0110; Ss identical to Sp.
REQ-024 tau1=127 (o=64) → Sp 0101→0001 (10 cycles)→1001 starting at a=64; Sp returns toward 0101 at a=191 via 0001.
REQ-025 phi=9, tau2=255 → every Ss edge lags the matching Sp edge by exactly 9 CE cycles; phi=-9 → Ss leads by 9.
REQ-026 Trigger at a=100 with tau1=50 → Sp unchanged until wrap; new widths from a=0; modo_act updates at wrap; a trigger with modo=3 changes nothing.
REQ-027 Target toggling twice within 10 cycles → deadtime restarts; no cycle exists in which any leg has both its switches on (1100, 0011).
REQ-028 rst=0 at a=300 → Sp=Ss=0000 immediately; after rst=1 the block waits in IDLE for a new sync edge.
